// File: rtl/data_mem_responder.sv
// Data-memory responder for the data cache memory port.
// One outstanding READ/WRITE, fixed latency, one-cycle FINISHED pulse.
module data_mem_responder #(
    parameter int ADDR_WIDTH       = 17,
    parameter int DATA_LEN         = 32,
    parameter int BYTE_SIZE        = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int LATENCY          = 2,
    parameter     INIT_FILE        = ""
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  mem_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       mem_vis_addr,
    input  logic [DATA_LEN-1:0]         mem_written_data,
    input  logic [2:0]                  written_data_type,
    input  logic [ENTRY_INDEX_SIZE:0]   write_length,
    output logic [DATA_LEN-1:0]         mem_data,
    output logic [1:0]                  mem_status,
    output logic                        err
);

    localparam logic [1:0] MEM_NOP   = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] MEM_RESTING       = 2'b00;
    localparam logic [1:0] MEM_WORKING       = 2'b01;
    localparam logic [1:0] MEM_DATA_FINISHED = 2'b10;

    localparam logic [2:0] ONE_BYTE  = 3'b000;
    localparam logic [2:0] TWO_BYTE  = 3'b001;
    localparam logic [2:0] FOUR_BYTE = 3'b010;

    localparam int NB    = DATA_LEN / BYTE_SIZE;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [CW-1:0]               r_cnt;
    logic [1:0]                  r_op;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [DATA_LEN-1:0]         r_wdata;
    logic [2:0]                  r_type;
    logic [ENTRY_INDEX_SIZE:0]   r_len;
    logic [DATA_LEN-1:0]         r_mem_data;
    logic                        r_err;
    logic [BYTE_SIZE-1:0]        r_mem [0:DEPTH-1];

    logic                        w_accept;
    logic                        w_fire;
    logic                        w_type_ok;
    logic                        w_legal;
    logic                        w_do_write;
    logic                        w_do_read;
    int                          w_nbytes;

    assign w_accept  = (r_state == S_IDLE) && (mem_vis_signal != MEM_NOP);
    assign w_fire    = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_type_ok = (r_type == ONE_BYTE) || (r_type == TWO_BYTE) ||
                       (r_type == FOUR_BYTE);
    // Length only matters for stores; op 2'b11 is never legal.
    assign w_legal   = w_type_ok && (r_op != 2'b11) &&
                       ((r_op != MEM_WRITE) || (r_len == 1));
    assign w_do_write = w_fire && (r_op == MEM_WRITE) && w_legal;
    assign w_do_read  = w_fire && (r_op != MEM_WRITE);

    always_comb begin
        w_nbytes = NB;
        if (r_type == ONE_BYTE)
            w_nbytes = 1;
        else if (r_type == TWO_BYTE)
            w_nbytes = 2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_status = MEM_RESTING;
        case (r_state)
            S_BUSY:  mem_status = MEM_WORKING;
            S_DONE:  mem_status = MEM_DATA_FINISHED;
            default: mem_status = MEM_RESTING;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op    <= MEM_NOP;
            r_addr  <= '0;
            r_wdata <= '0;
            r_type  <= '0;
            r_len   <= '0;
        end else if (w_accept) begin
            r_cnt   <= CW'(LATENCY - 1);
            r_op    <= mem_vis_signal;
            r_addr  <= mem_vis_addr;
            r_wdata <= mem_written_data;
            r_type  <= written_data_type;
            r_len   <= write_length;
        end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_data <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_do_read) begin
                for (int k = 0; k < NB; k++)
                    r_mem_data[DATA_LEN-1-k*BYTE_SIZE -: BYTE_SIZE] <=
                        r_mem[r_addr + ADDR_WIDTH'(k)];
            end
            if (w_fire && !w_legal)
                r_err <= 1'b1;
        end
    end

    // Array is intentionally never reset; addresses wrap at the top.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int k = 0; k < NB; k++)
                if (k < w_nbytes)
                    r_mem[r_addr + ADDR_WIDTH'(k)] <=
                        r_wdata[DATA_LEN-1-k*BYTE_SIZE -: BYTE_SIZE];
        end
    end

    assign mem_data = r_mem_data;
    assign err      = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, hand sequences,
// and random traffic against a byte-array reference model.
module tb_data_mem_responder;

    localparam int LAT = 2;
    localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10;
    localparam logic [1:0] ST_REST = 2'b00, ST_WORK = 2'b01, ST_FIN = 2'b10;
    localparam logic [2:0] T1 = 3'd0, T2 = 3'd1, T4 = 3'd2, T8 = 3'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sig = NOP;
    logic [16:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  typ = T4;
    logic [3:0]  len = 4'd1;
    logic [31:0] mem_data;
    logic [1:0]  mem_status;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd = '0;
    logic        err_m = 1'b0;
    logic [7:0]  ref_m [int];

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_vis_signal(sig), .mem_vis_addr(addr),
        .mem_written_data(wdata), .written_data_type(typ),
        .write_length(len), .mem_data(mem_data),
        .mem_status(mem_status), .err(err)
    );

    typedef struct {
        logic [1:0]  op;
        logic [16:0] a;
        logic [31:0] d;
        logic [2:0]  t;
        logic [3:0]  l;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mget(input int a);
        int k;
        k = a % 131072;
        return ref_m.exists(k) ? ref_m[k] : 8'h00;
    endfunction

    // Reference: bytes in memory order, store length from type, wrap at 2^17.
    task automatic model(input logic [1:0] op, input logic [16:0] a,
                         input logic [31:0] d, input logic [2:0] t,
                         input logic [3:0] l, output logic [31:0] rd);
        bit legal;
        int nb;
        legal = (t <= T4) && (op != WR || l == 4'd1);
        if (!legal) err_m = 1'b1;
        rd = last_rd;
        if (op == RD) begin
            for (int k = 0; k < 4; k++)
                rd = {rd[23:0], mget(int'(a) + k)};
        end else if (legal) begin
            nb = (t == T1) ? 1 : (t == T2) ? 2 : 4;
            for (int k = 0; k < nb; k++)
                ref_m[(int'(a) + k) % 131072] = d[31-8*k -: 8];
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after DONE.
    task automatic req(input logic [1:0] op, input logic [16:0] a,
                       input logic [31:0] d, input logic [2:0] t,
                       input logic [3:0] l, input logic [31:0] exp_rd,
                       input logic exp_err, input logic hold);
        int n;
        logic [31:0] e;
        e = (op == RD) ? exp_rd : last_rd;
        if (op == RD) last_rd = exp_rd;
        sig = op; addr = a; wdata = d; typ = t; len = l;
        @(negedge clk);
        if (!hold) begin
            sig = NOP;
            wdata = $urandom;
            addr = 17'($urandom);
        end
        n = 0;
        while (mem_status == ST_WORK && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, LAT);
        chk("finished", 32'(mem_status), 32'(ST_FIN));
        chk("mem_data", mem_data, e);
        chk("err", 32'(err), 32'(exp_err));
        @(negedge clk);
        chk("resting", 32'(mem_status), 32'(ST_REST));
    endtask

    task automatic mreq(input logic [1:0] op, input logic [16:0] a,
                        input logic [31:0] d, input logic [2:0] t,
                        input logic [3:0] l);
        logic [31:0] rd;
        model(op, a, d, t, l, rd);
        req(op, a, d, t, l, rd, err_m, 1'b0);
    endtask

    vec_t vt [$];

    initial begin
        vt.push_back('{WR, 17'h00010, 32'h11223344, T4, 4'd1, 32'h0, 1'b0});
        vt.push_back('{RD, 17'h00010, 32'h0, T4, 4'd1, 32'h11223344, 1'b0});
        vt.push_back('{WR, 17'h00020, 32'h0, T4, 4'd1, 32'h0, 1'b0});
        vt.push_back('{WR, 17'h00024, 32'h0, T4, 4'd1, 32'h0, 1'b0});
        vt.push_back('{WR, 17'h00023, 32'hABCD0000, T2, 4'd1, 32'h0, 1'b0});
        vt.push_back('{RD, 17'h00020, 32'h0, T4, 4'd1, 32'h000000AB, 1'b0});
        vt.push_back('{RD, 17'h00024, 32'h0, T4, 4'd1, 32'hCD000000, 1'b0});
        vt.push_back('{WR, 17'h00022, 32'h5A000000, T1, 4'd1, 32'h0, 1'b0});
        vt.push_back('{RD, 17'h00020, 32'h0, T4, 4'd1, 32'h00005AAB, 1'b0});
        vt.push_back('{WR, 17'h1FFFE, 32'hAABBCCDD, T4, 4'd1, 32'h0, 1'b0});
        vt.push_back('{RD, 17'h1FFFE, 32'h0, T4, 4'd1, 32'hAABBCCDD, 1'b0});
        vt.push_back('{WR, 17'h00014, 32'h55667788, T4, 4'd1, 32'h0, 1'b0});
        vt.push_back('{WR, 17'h00030, 32'h01020304, T4, 4'd1, 32'h0, 1'b0});
        vt.push_back('{WR, 17'h00030, 32'hFFFFFFFF, T8, 4'd1, 32'h0, 1'b1});
        vt.push_back('{RD, 17'h00030, 32'h0, T4, 4'd1, 32'h01020304, 1'b1});
        vt.push_back('{WR, 17'h00030, 32'hEEEEEEEE, T4, 4'd2, 32'h0, 1'b1});
        vt.push_back('{RD, 17'h00030, 32'h0, T4, 4'd1, 32'h01020304, 1'b1});

        repeat (2) @(negedge clk);
        chk("rst_status", 32'(mem_status), 32'(ST_REST));
        chk("rst_data", mem_data, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            req(vt[i].op, vt[i].a, vt[i].d, vt[i].t, vt[i].l,
                vt[i].exp_rd, vt[i].exp_err, 1'b0);
            err_m = vt[i].exp_err;
        end

        // Request held through DONE must not be taken twice.
        req(RD, 17'h10, 32'h0, T4, 4'd1, 32'h11223344, err_m, 1'b1);
        sig = NOP;
        @(negedge clk);
        chk("hold_no_reaccept", 32'(mem_status), 32'(ST_REST));
        req(RD, 17'h14, 32'h0, T4, 4'd1, 32'h55667788, err_m, 1'b0);

        // Reset in the second BUSY cycle of a store aborts it.
        req(WR, 17'h40, 32'h01020304, T4, 4'd1, 32'h0, err_m, 1'b0);
        sig = WR; addr = 17'h40; wdata = 32'hDEADBEEF; typ = T4; len = 4'd1;
        @(negedge clk);
        sig = NOP;
        chk("abort_busy", 32'(mem_status), 32'(ST_WORK));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_status", 32'(mem_status), 32'(ST_REST));
        chk("abort_data", mem_data, 32'h0);
        chk("abort_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
        err_m = 1'b0;
        @(negedge clk);
        req(RD, 17'h40, 32'h0, T4, 4'd1, 32'h01020304, 1'b0, 1'b0);

        ref_m.delete();
        for (int i = 0; i < 16; i++)
            mreq(WR, 17'(32'h100 + 4 * i), 32'h0, T4, 4'd1);
        for (int i = 0; i < 80; i++) begin
            logic [16:0] a;
            logic [2:0]  t;
            logic [3:0]  l;
            a = 17'(32'h100 + $urandom_range(0, 60));
            if ($urandom_range(0, 1) == 0) begin
                mreq(RD, a, 32'h0, T4, 4'd1);
            end else begin
                t = ($urandom_range(0, 9) == 0) ? T8 : 3'($urandom_range(0, 2));
                l = ($urandom_range(0, 9) == 0) ? 4'd2 : 4'd1;
                mreq(WR, a, $urandom, t, l);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
